// File: rtl/onehot_encoder_pipe.sv
// Registered one-hot/priority encoder with valid/ready on both sides.
// Flags zero and multi-hot vectors and keeps a saturating error count.
module onehot_encoder_pipe #(
    parameter int WIDTH     = 8,
    parameter int CODE_W    = 3,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit STRICT    = 1'b1,
    parameter int ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CODE_W-1:0]   out_code,
    output logic                out_zero,
    output logic                out_multi,
    output logic                out_err,
    input  logic                clr_err,
    output logic [ERRCNT_W-1:0] err_count
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("onehot_encoder_pipe: WIDTH must be >= 2");
        end
        if (CODE_W != $clog2(WIDTH)) begin : g_bad_code_w
            $error("onehot_encoder_pipe: CODE_W must equal $clog2(WIDTH)");
        end
    endgenerate

    logic [CODE_W-1:0] enc_code;
    logic              enc_found;
    logic              enc_zero;
    logic              enc_multi;
    logic              enc_err;
    logic              accept;

    // First set bit in scan order wins; order depends on MSB_FIRST.
    always_comb begin
        enc_code  = '0;
        enc_found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            int j;
            j = MSB_FIRST ? (WIDTH - 1 - i) : i;
            if (!enc_found && in_data[j]) begin
                enc_code  = CODE_W'(j);
                enc_found = 1'b1;
            end
        end
    end

    // x & (x-1) clears the lowest set bit; nonzero means 2+ bits set.
    assign enc_zero  = ~|in_data;
    assign enc_multi = |(in_data & (in_data - WIDTH'(1)));
    assign enc_err   = enc_zero | (enc_multi & STRICT);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_code  <= enc_code;
            out_zero  <= enc_zero;
            out_multi <= enc_multi;
            out_err   <= enc_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_count <= '0;
        end else if (accept && enc_err && (err_count != '1)) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed bench for onehot_encoder_pipe: three instances cover
// LSB-first/strict, MSB-first/strict and LSB-first/non-strict.
module tb_onehot_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       clr_err;

    logic       rdy0, vld0, zero0, multi0, err0;
    logic [2:0] code0;
    logic [7:0] cnt0;
    logic       rdy1, vld1, zero1, multi1, err1;
    logic [2:0] code1;
    logic [7:0] cnt1;
    logic       rdy2, vld2, zero2, multi2, err2;
    logic [2:0] code2;
    logic [7:0] cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.WIDTH(8), .CODE_W(3), .MSB_FIRST(1'b0),
                          .STRICT(1'b1), .ERRCNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .out_valid(vld0), .out_ready(out_ready),
        .out_code(code0), .out_zero(zero0), .out_multi(multi0),
        .out_err(err0), .clr_err(clr_err), .err_count(cnt0));

    onehot_encoder_pipe #(.WIDTH(8), .CODE_W(3), .MSB_FIRST(1'b1),
                          .STRICT(1'b1), .ERRCNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .out_valid(vld1), .out_ready(out_ready),
        .out_code(code1), .out_zero(zero1), .out_multi(multi1),
        .out_err(err1), .clr_err(clr_err), .err_count(cnt1));

    onehot_encoder_pipe #(.WIDTH(8), .CODE_W(3), .MSB_FIRST(1'b0),
                          .STRICT(1'b0), .ERRCNT_W(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .out_valid(vld2), .out_ready(out_ready),
        .out_code(code2), .out_zero(zero2), .out_multi(multi2),
        .out_err(err2), .clr_err(clr_err), .err_count(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_code", 32'(code0), 32'd0);
        chk("rst_zero", 32'(zero0), 32'd0);
        chk("rst_multi", 32'(multi0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_ready", 32'(rdy0), 32'd1);

        // walking one, full throughput
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 8'(1 << k);
            step();
            chk("walk_valid", 32'(vld0), 32'd1);
            chk("walk_code", 32'(code0), 32'(k));
            chk("walk_err", 32'(err0), 32'd0);
            chk("walk_msb_code", 32'(code1), 32'(k));
        end

        in_data = 8'h00;
        step();
        chk("zero_flag", 32'(zero0), 32'd1);
        chk("zero_code", 32'(code0), 32'd0);
        chk("zero_err", 32'(err0), 32'd1);
        chk("zero_cnt", 32'(cnt0), 32'd1);
        chk("zero_cnt_ns", 32'(cnt2), 32'd1);

        in_data = 8'b0110_1000;
        step();
        chk("multi_lsb_code", 32'(code0), 32'd3);
        chk("multi_lsb_flag", 32'(multi0), 32'd1);
        chk("multi_lsb_err", 32'(err0), 32'd1);
        chk("multi_lsb_cnt", 32'(cnt0), 32'd2);
        chk("multi_msb_code", 32'(code1), 32'd6);
        chk("multi_msb_flag", 32'(multi1), 32'd1);
        chk("multi_ns_flag", 32'(multi2), 32'd1);
        chk("multi_ns_err", 32'(err2), 32'd0);
        chk("multi_ns_cnt", 32'(cnt2), 32'd1);

        // backpressure
        in_data = 8'h04;
        step();
        chk("bp_load", 32'(code0), 32'd2);
        out_ready = 1'b0;
        in_data   = 8'h10;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_code", 32'(code0), 32'd2);
            chk("bp_valid", 32'(vld0), 32'd1);
            chk("bp_ready", 32'(rdy0), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rdy0), 32'd1);
        step();
        chk("bp_next_code", 32'(code0), 32'd4);
        chk("bp_next_valid", 32'(vld0), 32'd1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(vld0), 32'd0);

        // error counter saturation
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 252) chk("sat_pre", 32'(cnt0), 32'd254);
            if (k == 253) chk("sat_hit", 32'(cnt0), 32'd255);
        end
        chk("sat_hold", 32'(cnt0), 32'd255);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_cnt", 32'(cnt0), 32'd0);
        chk("clr_valid", 32'(vld0), 32'd1);
        chk("clr_zero", 32'(zero0), 32'd1);
        step();
        chk("clr_recount", 32'(cnt0), 32'd1);

        // reset during stall
        in_data = 8'h20;
        step();
        chk("rs_load", 32'(code0), 32'd5);
        out_ready = 1'b0;
        in_data   = 8'h40;
        step();
        chk("rs_stall_ready", 32'(rdy0), 32'd0);
        rst = 1'b1;
        step();
        chk("rs_valid", 32'(vld0), 32'd0);
        chk("rs_code", 32'(code0), 32'd0);
        chk("rs_zero", 32'(zero0), 32'd0);
        chk("rs_multi", 32'(multi0), 32'd0);
        chk("rs_err", 32'(err0), 32'd0);
        chk("rs_cnt", 32'(cnt0), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rs_ready", 32'(rdy0), 32'd1);
        step();
        chk("rs_no_replay", 32'(vld0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
